// File: rtl/usb_tx_pkg.sv
// USB full-speed transmit PHY shared definitions.
// FSM state encoding, SYNC pattern, stuffing limit and line states.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } state_e;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam int unsigned STUFF_LIMIT = 6;

  // {D+, D-}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_phy_nrzi_stuff.sv
// Bit stuffer and NRZI encoder for the USB transmit PHY.
// level_o=1 means J; stall_o flags that the next slot is a stuff bit.
module usb_nrzi_stuff
  import usb_tx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic load_i,
  input  logic adv_i,
  input  logic bit_i,
  output logic level_o,
  output logic stuff_o,
  output logic stall_o
);

  logic       level_q, level_d;
  logic       stuff_q, stuff_d;
  logic [2:0] ones_q, ones_d;

  assign stall_o = (ones_q == 3'(STUFF_LIMIT));
  assign level_o = level_q;
  assign stuff_o = stuff_q;

  // Next line level and run-of-ones tracking per emitted bit
  always_comb begin
    level_d = level_q;
    stuff_d = stuff_q;
    ones_d  = ones_q;
    if (clr_i) begin
      level_d = 1'b1;
      stuff_d = 1'b0;
      ones_d  = 3'd0;
    end else if (load_i) begin
      // line rests at J before the first bit
      level_d = bit_i;
      stuff_d = 1'b0;
      ones_d  = {2'b00, bit_i};
    end else if (adv_i) begin
      if (stall_o) begin
        level_d = ~level_q;
        stuff_d = 1'b1;
        ones_d  = 3'd0;
      end else begin
        level_d = bit_i ? level_q : ~level_q;
        stuff_d = 1'b0;
        ones_d  = bit_i ? ones_q + 3'd1 : 3'd0;
      end
    end
  end

  // Encoder state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b1;
      stuff_q <= 1'b0;
      ones_q  <= 3'd0;
    end else begin
      level_q <= level_d;
      stuff_q <= stuff_d;
      ones_q  <= ones_d;
    end
  end

endmodule

// File: rtl/usb_tx_phy.sv
// USB full-speed transmit PHY: SYNC, byte fetch, stuffing/NRZI, EOP.
// Optional debug port enabled by defining USB_TX_PHY_DEBUG_EN.
module usb_tx_phy
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
  output logic       usb_tx_en,
  output logic       busy,
`ifdef USB_TX_PHY_DEBUG_EN
  output logic [3:0] debug,
`endif
  output logic       tx_underrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sr_q, sr_d;
  logic          last_q, last_d;
  logic          pend_q, pend_d;

  logic       strobe;
  logic       load, adv, clr, nbit;
  logic       fetch, end_pkt;
  logic       level, stuff_act, stall;
  logic [2:0] idx_inc;
  logic [1:0] line;

  assign strobe  = (state_q != ST_IDLE) &&
                   (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign idx_inc = idx_q + 3'd1;

  usb_nrzi_stuff u_enc (
    .clk_i   (clk_48mhz),
    .rst_i   (reset),
    .clr_i   (clr),
    .load_i  (load),
    .adv_i   (adv),
    .bit_i   (nbit),
    .level_o (level),
    .stuff_o (stuff_act),
    .stall_o (stall)
  );

  // Packet FSM: bit sequencing, byte fetch and EOP timing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    last_d  = last_q;
    pend_d  = pend_q;
    load    = 1'b0;
    adv     = 1'b0;
    clr     = 1'b0;
    nbit    = 1'b0;
    fetch   = 1'b0;
    end_pkt = 1'b0;
    if (state_q != ST_IDLE) begin
      cnt_d = strobe ? '0 : cnt_q + CW'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (tx_valid) begin
          state_d = ST_SYNC;
          sr_d    = SYNC_BYTE;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          load    = 1'b1;
          nbit    = SYNC_BYTE[0];
        end
      end
      ST_SYNC, ST_DATA: begin
        if (strobe) begin
          if (stuff_act) begin
            if (pend_q) begin
              state_d = ST_EOP_SE0;
              idx_d   = 3'd0;
              clr     = 1'b1;
            end else begin
              adv  = 1'b1;
              nbit = sr_q[idx_q];
            end
          end else if (idx_q != 3'd7) begin
            idx_d = idx_inc;
            adv   = 1'b1;
            nbit  = sr_q[idx_inc];
          end else if (state_q == ST_DATA && last_q) begin
            end_pkt = 1'b1;
          end else begin
            fetch = 1'b1;
            if (tx_valid) begin
              state_d = ST_DATA;
              sr_d    = tx_data;
              last_d  = tx_last;
              idx_d   = 3'd0;
              adv     = 1'b1;
              nbit    = tx_data[0];
            end else begin
              end_pkt = 1'b1;
            end
          end
          // a pending stuff bit still goes out before EOP
          if (end_pkt) begin
            if (stall) begin
              pend_d = 1'b1;
              adv    = 1'b1;
            end else begin
              state_d = ST_EOP_SE0;
              idx_d   = 3'd0;
              clr     = 1'b1;
            end
          end
        end
      end
      ST_EOP_SE0: begin
        if (strobe) begin
          if (idx_q == 3'd1) begin
            state_d = ST_EOP_J;
            idx_d   = 3'd0;
          end else begin
            idx_d = 3'd1;
          end
        end
      end
      ST_EOP_J: begin
        if (strobe) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = 3'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      sr_q    <= 8'h00;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  // Line driver selection from state and NRZI level
  always_comb begin
    line = LINE_J;
    unique case (1'b1)
      (state_q == ST_EOP_SE0): line = LINE_SE0;
      (state_q == ST_SYNC),
      (state_q == ST_DATA):    line = level ? LINE_J : LINE_K;
      default:                 line = LINE_J;
    endcase
  end

  assign usb_p_tx    = line[1];
  assign usb_n_tx    = line[0];
  assign busy        = (state_q != ST_IDLE);
  assign usb_tx_en   = busy;
  assign tx_ready    = fetch & ~reset;
  assign tx_underrun = fetch & ~tx_valid & ~reset;

`ifdef USB_TX_PHY_DEBUG_EN
  assign debug = reset ? 4'd0 : {state_q, stuff_act};
`endif

endmodule

// File: tb/tb_usb_tx_phy.sv
// Scoreboard bench for usb_tx_phy.
// Driver queues expected line/packet data; monitor pops and compares.
module tb_usb_tx_phy;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready, usb_p_tx, usb_n_tx;
  logic       usb_tx_en, busy, tx_underrun;
`ifdef USB_TX_PHY_DEBUG_EN
  logic [3:0] debug;
`endif

  usb_tx_phy #(.CLKS_PER_BIT(CPB)) dut (
    .clk_48mhz   (clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .usb_p_tx    (usb_p_tx),
    .usb_n_tx    (usb_n_tx),
    .usb_tx_en   (usb_tx_en),
    .busy        (busy),
`ifdef USB_TX_PHY_DEBUG_EN
    .debug       (debug),
`endif
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          n_ready;
    int          gap;
    int          n_under;
    int          dec;
    logic [23:0] bytes;
  } pkt_t;

  pkt_t       exp_pkt_q[$];
  logic [1:0] exp_line_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int pkts_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference line: stuff after six ones, NRZI from J, then SE0 SE0 J
  task automatic expect_pkt(input logic [23:0] bytes, input int nbytes,
                            input int trunc, input int len,
                            input int n_ready, input int gap,
                            input int n_under, input int dec);
    bit         bits[$];
    bit         st[$];
    logic [1:0] sym[$];
    logic [7:0] sb;
    int         ones;
    int         c;
    logic       lvl;
    pkt_t       p;
    sb = 8'h80;
    for (int i = 0; i < 8; i++) bits.push_back(sb[i]);
    for (int k = 0; k < nbytes; k++)
      for (int i = 0; i < 8; i++) bits.push_back(bytes[8*k+i]);
    ones = 0;
    foreach (bits[i]) begin
      st.push_back(bits[i]);
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        st.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = 1'b1;
    foreach (st[i]) begin
      if (!st[i]) lvl = ~lvl;
      sym.push_back(lvl ? 2'b10 : 2'b01);
    end
    sym.push_back(2'b00);
    sym.push_back(2'b00);
    sym.push_back(2'b10);
    c = 0;
    foreach (sym[i])
      for (int j = 0; j < CPB; j++) begin
        if (trunc == 0 || c < trunc) exp_line_q.push_back(sym[i]);
        c++;
      end
    p.len = len;
    p.n_ready = n_ready;
    p.gap = gap;
    p.n_under = n_under;
    p.dec = dec;
    p.bytes = bytes;
    exp_pkt_q.push_back(p);
  endtask

  // Offer n bytes; stop offering after 'offered' have been taken
  task automatic send(input logic [23:0] bytes, input int n,
                      input int offered);
    int k;
    int budget;
    k = 0;
    budget = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = bytes[7:0];
    tx_last = (n == 1);
    @(posedge clk);
    while (k < offered && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (tx_ready) begin
        k++;
        @(posedge clk);
        #1;
        if (k < offered) begin
          tx_data = bytes[8*k+:8];
          tx_last = (k == n - 1);
        end else begin
          tx_valid = 1'b0;
          tx_last = 1'b0;
        end
      end
    end
    if (k < offered) tx_valid = 1'b0;
    chk("handshake", k, offered);
  endtask

  task automatic wait_done(input int target);
    int b;
    b = 0;
    while (pkts_done < target && b < 3000) begin
      @(negedge clk);
      b++;
    end
    chk("pkt_done", pkts_done, target);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_en"}, usb_tx_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_line"}, {usb_p_tx, usb_n_tx}, 2);
    chk({tag, "_ready"}, tx_ready, 0);
    chk({tag, "_under"}, tx_underrun, 0);
  endtask

  // Monitor: per-cycle line check, decode, packet-level checks
  initial begin : mon
    int         cyc;
    int         rdy[$];
    int         nund;
    int         ones;
    logic       prev_en;
    logic       on;
    logic [1:0] prev_sym;
    logic [1:0] s;
    logic [1:0] e;
    logic [7:0] v;
    bit         dec[$];
    pkt_t       p;
    cyc = 0;
    nund = 0;
    ones = 0;
    prev_en = 1'b0;
    on = 1'b0;
    prev_sym = 2'b10;
    forever begin
      @(negedge clk);
      s = {usb_p_tx, usb_n_tx};
      if (usb_tx_en) begin
        cyc++;
        if (cyc == 1) begin
          prev_sym = 2'b10;
          ones = 0;
          on = 1'b1;
          nund = 0;
          rdy.delete();
          dec.delete();
        end
        e = (exp_line_q.size() > 0) ? exp_line_q.pop_front() : 2'b11;
        chk("line", s, e);
        chk("busy", busy, 1);
        if (tx_ready) rdy.push_back(cyc);
        if (tx_underrun) nund++;
        if (cyc % CPB == 1) begin
          if (s == 2'b00) on = 1'b0;
          else if (on) begin
            if (ones == 6) ones = 0;
            else begin
              dec.push_back(s == prev_sym);
              ones = (s == prev_sym) ? ones + 1 : 0;
            end
            prev_sym = s;
          end
        end
      end else if (prev_en) begin
        if (exp_pkt_q.size() > 0) p = exp_pkt_q.pop_front();
        else p = '{len: -1, n_ready: -1, gap: 0, n_under: -1,
                   dec: -1, bytes: 24'h0};
        chk("len", cyc, p.len);
        chk("n_ready", rdy.size(), p.n_ready);
        if (rdy.size() > 0) chk("first_ready", rdy[0], 8 * CPB);
        if (p.gap > 0)
          for (int i = 1; i < rdy.size(); i++)
            chk("ready_gap", rdy[i] - rdy[i-1], p.gap);
        chk("underrun", nund, p.n_under);
        if (p.dec >= 0) begin
          chk("dec_len", dec.size(), 8 + 8 * p.dec);
          for (int k = 0; k <= p.dec; k++) begin
            v = 8'h00;
            for (int i = 0; i < 8; i++)
              if (8 * k + i < dec.size()) v[i] = dec[8*k+i];
            if (k == 0) chk("dec_sync", v, 8'h80);
            else chk("dec_byte", v, p.bytes[8*(k-1)+:8]);
          end
        end
        chk("idle_line", s, 2'b10);
        chk("idle_busy", busy, 0);
        exp_line_q.delete();
        cyc = 0;
        pkts_done++;
      end
      prev_en = usb_tx_en;
    end
  end

`ifdef USB_TX_PHY_DEBUG_EN
  // State sequence seen on debug during the first packet
  initial begin : dbg_mon
    logic [2:0] seq[$];
    logic [2:0] exp_s[5];
    logic [2:0] last_s;
    int         k;
    exp_s = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    last_s = 3'd0;
    k = 0;
    while (pkts_done < 1 && k < 5000) begin
      @(negedge clk);
      k++;
      if (!reset && debug[3:1] != last_s) begin
        seq.push_back(debug[3:1]);
        last_s = debug[3:1];
      end
    end
    chk("dbg_nseq", seq.size(), 5);
    for (int i = 0; i < seq.size() && i < 5; i++)
      chk("dbg_state", seq[i], exp_s[i]);
  end
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : drv
    repeat (3) @(negedge clk);
    chk_idle("rst");
`ifdef USB_TX_PHY_DEBUG_EN
    chk("dbg_reset", debug, 0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8'h00 single byte: 19 bits
    expect_pkt(24'h000000, 1, 0, 76, 1, 0, 0, 1);
    send(24'h000000, 1, 1);
    wait_done(1);

    // 8'hFF: one stuff bit after the 5th data bit
    expect_pkt(24'h0000FF, 1, 0, 80, 1, 0, 0, 1);
    send(24'h0000FF, 1, 1);
    wait_done(2);

    // three bytes, no stuffing
    expect_pkt(24'hC33CA5, 3, 0, 140, 3, 32, 0, 3);
    send(24'hC33CA5, 3, 3);
    wait_done(3);

    // underrun at the second fetch
    expect_pkt(24'h00005A, 1, 0, 76, 2, 32, 1, 1);
    send(24'h00005A, 3, 1);
    wait_done(4);

    // trailing stuff bit after the final data bit
    expect_pkt(24'h0000FC, 1, 0, 80, 1, 0, 0, 1);
    send(24'h0000FC, 1, 1);
    wait_done(5);

    // stuff inside first byte delays the second fetch by one bit
    expect_pkt(24'h00FF7E, 2, 0, 116, 2, 36, 0, 2);
    send(24'h00FF7E, 2, 2);
    wait_done(6);

    // reset during cycle 30 of a packet: no EOP
    expect_pkt(24'h000000, 0, 30, 30, 0, 0, 0, -1);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = 8'h11;
    tx_last = 1'b1;
    @(posedge clk);
    repeat (29) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    chk_idle("trunc");
    reset = 1'b0;
    wait_done(7);

    // fresh packet after reset starts clean
    expect_pkt(24'h0000FF, 1, 0, 80, 1, 0, 0, 1);
    send(24'h0000FF, 1, 1);
    wait_done(8);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
